life_engine: RTL and testbench

LIFE_ENGINE -- requirements
Module: life_engine

---
 rtl/life_engine.sv | 196 +++++++++++++++++++
 tb/tb_life_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_engine.sv
// life_engine: Conway's Game of Life engine over a GRID_W x GRID_H bit grid.
// Cells are loaded one at a time. A step scans every cell in raster order,
// builds the next generation in a shadow grid, and then commits it in one
// cycle. A clear scans the grid and kills every live cell. Each cell that
// changes produces one pixel plot, so an external framebuffer can follow the
// grid incrementally.
// Optional feature macro: LIFE_WRAP_EN makes neighbour lookup toroidal. When
// it is undefined, off-grid neighbours count as dead.
//
// Handshake: load, step and clear are level requests sampled on a rising
// clock edge only while busy=0. A request that loses the arbitration
// (clear > load > step) or arrives while busy=1 is dropped, not queued.
// plot is a one-cycle valid qualifying out_x/out_y/out_color; those hold
// their last value whenever plot=0. done is a one-cycle pulse.
module life_engine #(
  parameter int          GRID_W       = 16,
  parameter int          GRID_H       = 16,
  parameter int          COORD_W      = 8,
  parameter logic [2:0]  ALIVE_COLOUR = 3'b111,
  localparam int         POP_W        = $clog2(GRID_W * GRID_H + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic               step,
  input  logic               clear,
  output logic               busy,
  output logic               done,
  output logic               plot,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [2:0]         out_color,
  output logic [15:0]        generation,
  output logic [POP_W-1:0]   pop_count
);

  localparam int CELLS = GRID_W * GRID_H;
  localparam int IDX_W = $clog2(CELLS);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, CLEAR} state_t;

  // state is kept as a named signal so checkers can bind to it
  state_t             state;
  logic [CELLS-1:0]   cur_grid;
  logic [CELLS-1:0]   next_grid;
  logic [COORD_W-1:0] scan_x;
  logic [COORD_W-1:0] scan_y;
  logic [POP_W-1:0]   pop_acc;

  logic [IDX_W-1:0]   scan_idx;
  logic [IDX_W-1:0]   load_idx;
  logic [3:0]         nbr_count;
  logic               cell_now;
  logic               cell_next;
  logic               load_ok;
  logic               scan_last;

  assign scan_idx  = IDX_W'(int'(scan_y) * GRID_W + int'(scan_x));
  assign load_idx  = IDX_W'(int'(y_in) * GRID_W + int'(x_in));
  assign load_ok   = (int'(x_in) < GRID_W) && (int'(y_in) < GRID_H);
  assign scan_last = (int'(scan_x) == GRID_W - 1) && (int'(scan_y) == GRID_H - 1);
  assign cell_now  = cur_grid[scan_idx];
  assign busy      = (state != IDLE);

  // Count the live neighbours of the visited cell in the current generation
  always_comb begin : nbr_sum
    int nx;
    int ny;
    nbr_count = '0;
    nx = 0;
    ny = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (!(dx == 0 && dy == 0)) begin
          nx = int'(scan_x) + dx;
          ny = int'(scan_y) + dy;
`ifdef LIFE_WRAP_EN
          if (nx < 0) nx = GRID_W - 1;
          else if (nx >= GRID_W) nx = 0;
          if (ny < 0) ny = GRID_H - 1;
          else if (ny >= GRID_H) ny = 0;
          nbr_count = nbr_count + 4'(cur_grid[IDX_W'(ny * GRID_W + nx)]);
`else
          if (nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H)
            nbr_count = nbr_count + 4'(cur_grid[IDX_W'(ny * GRID_W + nx)]);
`endif
        end
      end
    end
  end

  // Life rule: survive on 2 or 3 neighbours, birth on exactly 3
  always_comb begin
    cell_next = 1'b0;
    if (cell_now) cell_next = (nbr_count == 4'd2) || (nbr_count == 4'd3);
    else          cell_next = (nbr_count == 4'd3);
  end

  // Control FSM, grids and all registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cur_grid   <= '0;
      next_grid  <= '0;
      scan_x     <= '0;
      scan_y     <= '0;
      pop_acc    <= '0;
      done       <= 1'b0;
      plot       <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_color  <= 3'b000;
      generation <= 16'd0;
      pop_count  <= '0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            state  <= CLEAR;
            scan_x <= '0;
            scan_y <= '0;
          end else if (load) begin
            // Loading an already-live cell must not plot or recount it
            if (load_ok && !cur_grid[load_idx]) begin
              cur_grid[load_idx] <= 1'b1;
              pop_count          <= pop_count + POP_W'(1);
              plot               <= 1'b1;
              out_x              <= x_in;
              out_y              <= y_in;
              out_color          <= ALIVE_COLOUR;
            end
          end else if (step) begin
            state   <= SCAN;
            scan_x  <= '0;
            scan_y  <= '0;
            pop_acc <= '0;
          end
        end
        SCAN: begin
          // cur_grid stays frozen here; results go to the shadow grid
          next_grid[scan_idx] <= cell_next;
          pop_acc             <= pop_acc + POP_W'(cell_next);
          if (cell_next != cell_now) begin
            plot      <= 1'b1;
            out_x     <= scan_x;
            out_y     <= scan_y;
            out_color <= cell_next ? ALIVE_COLOUR : 3'b000;
          end
          if (int'(scan_x) == GRID_W - 1) begin
            scan_x <= '0;
            scan_y <= scan_y + COORD_W'(1);
          end else begin
            scan_x <= scan_x + COORD_W'(1);
          end
          if (scan_last) state <= COMMIT;
        end
        COMMIT: begin
          cur_grid   <= next_grid;
          pop_count  <= pop_acc;
          generation <= generation + 16'd1;
          done       <= 1'b1;
          state      <= IDLE;
        end
        CLEAR: begin
          // Only live cells need a plot to erase them from the display
          if (cell_now) begin
            cur_grid[scan_idx] <= 1'b0;
            plot               <= 1'b1;
            out_x              <= scan_x;
            out_y              <= scan_y;
            out_color          <= 3'b000;
          end
          if (int'(scan_x) == GRID_W - 1) begin
            scan_x <= '0;
            scan_y <= scan_y + COORD_W'(1);
          end else begin
            scan_x <= scan_x + COORD_W'(1);
          end
          if (scan_last) begin
            next_grid  <= '0;
            generation <= 16'd0;
            pop_count  <= '0;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed scoreboard bench for life_engine on an 8x8 grid.
// Driver tasks push the plots each operation must produce onto exp_q; a
// monitor pops and compares on every plot. Build with LIFE_WRAP_EN defined
// to select the toroidal boundary expectations.
module tb_life_engine;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int CW = 8;
  localparam int PW = $clog2(W * H + 1);

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          load    = 1'b0;
  logic [CW-1:0] x_in    = '0;
  logic [CW-1:0] y_in    = '0;
  logic          step    = 1'b0;
  logic          clear   = 1'b0;
  logic          busy;
  logic          done;
  logic          plot;
  logic [CW-1:0] out_x;
  logic [CW-1:0] out_y;
  logic [2:0]    out_color;
  logic [15:0]   generation;
  logic [PW-1:0] pop_count;

  int total = 0;
  int bad   = 0;
  logic [2*CW+2:0] exp_q[$];

  life_engine #(
    .GRID_W(W), .GRID_H(H), .COORD_W(CW), .ALIVE_COLOUR(3'b111)
  ) dut (
    .clock(clock), .reset_n(reset_n), .load(load), .x_in(x_in), .y_in(y_in),
    .step(step), .clear(clear), .busy(busy), .done(done), .plot(plot),
    .out_x(out_x), .out_y(out_y), .out_color(out_color),
    .generation(generation), .pop_count(pop_count)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // monitor: every plot must match the head of the expected queue
  always @(negedge clock) begin
    if (plot) begin : mon
      logic [2*CW+2:0] got;
      logic [2*CW+2:0] e;
      got = {out_x, out_y, out_color};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL plot_extra: got (%0d,%0d,%b) want no plot", out_x, out_y, out_color);
      end else begin
        e = exp_q.pop_front();
        if (e != got) begin
          bad++;
          $display("FAIL plot: got (%0d,%0d,%b) want (%0d,%0d,%b)", out_x, out_y, out_color,
                   e[2*CW+2:CW+3], e[CW+2:3], e[2:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_plot(input int x, input int y, input logic [2:0] c);
    exp_q.push_back({CW'(x), CW'(y), c});
  endtask

  task automatic do_load(input int x, input int y, input bit accepted);
    x_in = CW'(x);
    y_in = CW'(y);
    load = 1'b1;
    if (accepted) expect_plot(x, y, 3'b111);
    tick();
    load = 1'b0;
  endtask

  // step; optionally pulse load(5,5)+step during SCAN at cycle inject
  task automatic do_step(input int inject);
    int cyc;
    step = 1'b1;
    tick();
    step = 1'b0;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc == inject) begin
        load = 1'b1;
        step = 1'b1;
        x_in = 8'd5;
        y_in = 8'd5;
      end else begin
        load = 1'b0;
        step = 1'b0;
      end
    end while (!done && cyc < 200);
    load = 1'b0;
    step = 1'b0;
    check("step_latency", cyc, W * H + 1);
    tick();
    check("step_queue_empty", exp_q.size(), 0);
  endtask

  task automatic wait_clear_done(input string name);
    int cyc;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < 200);
    check(name, cyc, W * H);
    tick();
    check("clear_queue_empty", exp_q.size(), 0);
    check("clear_pop", pop_count, 0);
    check("clear_gen", generation, 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    wait_clear_done("clear_latency");
  endtask

  initial begin
    // reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_plot", plot, 0);
    check("rst_out", {out_x, out_y, out_color}, 0);
    check("rst_gen", generation, 0);
    check("rst_pop", pop_count, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // blinker: horizontal -> vertical
    do_load(2, 3, 1);
    do_load(3, 3, 1);
    do_load(4, 3, 1);
    tick();
    check("blink_load_pop", pop_count, 3);
    expect_plot(3, 2, 3'b111);
    expect_plot(2, 3, 3'b000);
    expect_plot(4, 3, 3'b000);
    expect_plot(3, 4, 3'b111);
    do_step(0);
    check("blink_pop", pop_count, 3);
    check("blink_gen", generation, 1);
    expect_plot(3, 2, 3'b000);
    expect_plot(3, 3, 3'b000);
    expect_plot(3, 4, 3'b000);
    do_clear();

    // block still life
    do_load(0, 0, 1);
    do_load(1, 0, 1);
    do_load(0, 1, 1);
    do_load(1, 1, 1);
    do_step(0);
    check("block_pop", pop_count, 4);
    check("block_gen", generation, 1);
    expect_plot(0, 0, 3'b000);
    expect_plot(1, 0, 3'b000);
    expect_plot(0, 1, 3'b000);
    expect_plot(1, 1, 3'b000);
    do_clear();

    // vertical line on the right edge
    do_load(7, 0, 1);
    do_load(7, 1, 1);
    do_load(7, 2, 1);
`ifdef LIFE_WRAP_EN
    expect_plot(7, 0, 3'b000);
    expect_plot(0, 1, 3'b111);
    expect_plot(6, 1, 3'b111);
    expect_plot(7, 2, 3'b000);
    do_step(0);
    check("edge_pop", pop_count, 3);
    expect_plot(0, 1, 3'b000);
    expect_plot(6, 1, 3'b000);
    expect_plot(7, 1, 3'b000);
`else
    expect_plot(7, 0, 3'b000);
    expect_plot(6, 1, 3'b111);
    expect_plot(7, 2, 3'b000);
    do_step(0);
    check("edge_pop", pop_count, 2);
    expect_plot(6, 1, 3'b000);
    expect_plot(7, 1, 3'b000);
`endif
    do_clear();

    // ignored requests
    do_load(9, 2, 0);
    do_load(2, 9, 0);
    tick();
    check("oob_pop", pop_count, 0);
    do_load(1, 1, 1);
    do_load(1, 1, 0);
    tick();
    check("dup_pop", pop_count, 1);
    expect_plot(1, 1, 3'b000);
    do_step(5);
    check("inject_pop", pop_count, 0);
    check("inject_gen", generation, 1);
    tick();
    check("inject_idle", busy, 0);
    do_load(4, 4, 1);
    x_in = 8'd2;
    y_in = 8'd2;
    load = 1'b1;
    clear = 1'b1;
    expect_plot(4, 4, 3'b000);
    tick();
    load = 1'b0;
    clear = 1'b0;
    check("clear_wins_busy", busy, 1);
    wait_clear_done("clear_wins_latency");

    // reset during SCAN
    do_load(2, 3, 1);
    do_load(3, 3, 1);
    do_load(4, 3, 1);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (10) tick();
    check("scan_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_pop", pop_count, 0);
    check("abort_gen", generation, 0);
    check("abort_plot", plot, 0);
    repeat (3) begin
      tick();
      check("abort_done", done, 0);
    end
    reset_n = 1'b1;
    tick();
    check("abort_done_after", done, 0);
    do_step(0);
    check("empty_pop", pop_count, 0);
    check("empty_gen", generation, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
